// File: rtl/cpu_arb_pkg.sv
// Shared types for the CPU instruction/data memory-port arbiter.
// Bus phase, owner encoding and one-hot grant codes.
package cpu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ACK
    } state_t;

    typedef enum logic {
        OWN_INST,
        OWN_DATA
    } owner_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_INST = 2'b01;
    localparam logic [1:0] GRANT_DATA = 2'b10;

    function automatic logic [1:0] grant_of(owner_t o);
        return (o == OWN_DATA) ? GRANT_DATA : GRANT_INST;
    endfunction

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Signal bundle between the CPU masters, the arbiter and the memory port.
// slave = arbiter side, master = CPU masters plus memory fabric.
interface cpu_mem_arbiter_if #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int BEW = 2
);
    logic          inst_cyc_in;
    logic          inst_stb_in;
    logic [AW-1:0] inst_addr_in;
    logic          inst_stall_out;
    logic          inst_ack_out;
    logic [DW-1:0] inst_data_out;
    logic          inst_err_out;

    logic           data_stb_in;
    logic           data_we_in;
    logic [BEW-1:0] data_be_in;
    logic [AW-1:0]  data_addr_in;
    logic [DW-1:0]  data_data_in;
    logic           data_ack_out;
    logic [DW-1:0]  data_data_out;
    logic           data_err_out;

    logic           mem_cyc_out;
    logic           mem_stb_out;
    logic           mem_we_out;
    logic [BEW-1:0] mem_be_out;
    logic [AW-1:0]  mem_addr_out;
    logic [DW-1:0]  mem_data_out;
    logic [DW-1:0]  mem_data_in;
    logic           mem_ack_in;
    logic           mem_stall_in;

    logic [1:0] grant_out;

    modport slave (
        input  inst_cyc_in, inst_stb_in, inst_addr_in,
        output inst_stall_out, inst_ack_out, inst_data_out, inst_err_out,
        input  data_stb_in, data_we_in, data_be_in,
        input  data_addr_in, data_data_in,
        output data_ack_out, data_data_out, data_err_out,
        output mem_cyc_out, mem_stb_out, mem_we_out, mem_be_out,
        output mem_addr_out, mem_data_out,
        input  mem_data_in, mem_ack_in, mem_stall_in,
        output grant_out
    );

    modport master (
        output inst_cyc_in, inst_stb_in, inst_addr_in,
        input  inst_stall_out, inst_ack_out, inst_data_out, inst_err_out,
        output data_stb_in, data_we_in, data_be_in,
        output data_addr_in, data_data_in,
        input  data_ack_out, data_data_out, data_err_out,
        input  mem_cyc_out, mem_stb_out, mem_we_out, mem_be_out,
        input  mem_addr_out, mem_data_out,
        output mem_data_in, mem_ack_in, mem_stall_in,
        input  grant_out
    );

endinterface

// File: rtl/cpu_arb_timer.sv
// Saturating ack-wait counter; expired flags the last allowed cycle.
// MAX of zero never expires.
module cpu_arb_timer #(
    parameter int unsigned MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int TW = (MAX > 0) ? $clog2(MAX + 1) : 1;

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && cnt != TW'(MAX))
            cnt <= cnt + TW'(1);
    end

    assign expired = (MAX != 0) && (cnt == TW'(MAX - 1));

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one pipelined memory port between instruction fetch and data masters.
// One transaction at a time, alternating grants on conflict, ack timeout.
module cpu_mem_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int             AW      = 32,
    parameter int             DW      = 32,
    parameter int             BEW     = 2,
    parameter logic [BEW-1:0] INST_BE = 2'b11,
    parameter int unsigned    TIMEOUT = 255
) (
    input logic               sys_clk,
    input logic               sys_rst,
    cpu_mem_arbiter_if.slave  bus
);
    state_t state, state_d;
    owner_t owner, owner_d;
    owner_t last_grant, last_grant_d;

    logic inst_req, data_req;
    logic load, accept, in_wait, cyc;
    logic ack_hit, timed_out, expired;

    logic [AW-1:0]  addr_q;
    logic           we_q;
    logic [BEW-1:0] be_q;
    logic [DW-1:0]  wdata_q;
    logic [DW-1:0]  inst_rdata_q;
    logic [DW-1:0]  data_rdata_q;

    assign inst_req  = bus.inst_cyc_in & bus.inst_stb_in;
    assign data_req  = bus.data_stb_in;
    assign in_wait   = (state == WAIT_ACK);
    assign accept    = (state == REQ) & ~bus.mem_stall_in;
    assign ack_hit   = in_wait & bus.mem_ack_in;
    assign timed_out = in_wait & ~bus.mem_ack_in & expired;
    assign cyc       = (state != IDLE);

    always_comb begin
        state_d      = state;
        owner_d      = owner;
        last_grant_d = last_grant;
        load         = 1'b0;
        unique case (state)
            IDLE: begin
                if (inst_req | data_req) begin
                    load    = 1'b1;
                    state_d = REQ;
                    if (inst_req & data_req)
                        owner_d = (last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
                    else
                        owner_d = data_req ? OWN_DATA : OWN_INST;
                    last_grant_d = owner_d;
                end
            end
            REQ: begin
                if (accept)
                    state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_hit | timed_out)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            owner        <= OWN_INST;
            last_grant   <= OWN_INST;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            last_grant <= last_grant_d;
            if (load) begin
                if (owner_d == OWN_DATA) begin
                    addr_q  <= bus.data_addr_in;
                    we_q    <= bus.data_we_in;
                    be_q    <= bus.data_be_in;
                    wdata_q <= bus.data_data_in;
                end else begin
                    addr_q  <= bus.inst_addr_in;
                    we_q    <= 1'b0;
                    be_q    <= INST_BE;
                    wdata_q <= '0;
                end
            end
            if (ack_hit && owner == OWN_INST)
                inst_rdata_q <= bus.mem_data_in;
            if (ack_hit && owner == OWN_DATA)
                data_rdata_q <= bus.mem_data_in;
        end
    end

    cpu_arb_timer #(
        .MAX (TIMEOUT)
    ) u_timer (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .clr     (accept),
        .en      (in_wait),
        .expired (expired)
    );

    // Bus fields are gated by cyc so the port is quiet between transactions.
    assign bus.mem_cyc_out  = cyc;
    assign bus.mem_stb_out  = (state == REQ);
    assign bus.mem_we_out   = cyc & we_q;
    assign bus.mem_be_out   = cyc ? be_q : '0;
    assign bus.mem_addr_out = cyc ? addr_q : '0;
    assign bus.mem_data_out = cyc ? wdata_q : '0;
    assign bus.grant_out    = cyc ? grant_of(owner) : GRANT_NONE;

    assign bus.inst_ack_out  = ack_hit & (owner == OWN_INST);
    assign bus.data_ack_out  = ack_hit & (owner == OWN_DATA);
    assign bus.inst_err_out  = timed_out & (owner == OWN_INST);
    assign bus.data_err_out  = timed_out & (owner == OWN_DATA);
    assign bus.inst_data_out = bus.inst_ack_out ? bus.mem_data_in : inst_rdata_q;
    assign bus.data_data_out = bus.data_ack_out ? bus.mem_data_in : data_rdata_q;

    assign bus.inst_stall_out = inst_req & ~(accept & (owner == OWN_INST));

endmodule
